leds_driver: RTL
================

LEDS_DRIVER -- requirements
Module: leds_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 1: clocks per PWM tick; legal range 1..65535.
REQ-002 SHALL have parameter STEP, default 16: brightness change per PWM period; legal range 1..255.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: when 1, LED pins are driven low for "lit".
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port ctrl_en, input, 1 bit: global enable from the LED bus interface.
REQ-007 SHALL have ports ctrl_led0..ctrl_led3, inputs, 1 bit each: requested on/off state per LED.
REQ-008 SHALL have ports led0..led3, outputs, 1 bit each: registered PWM pin drive.
REQ-009 SHALL have port ramping, output, 1 bit: high while any enabled LED level differs from its target.

Function
REQ-010 SHALL register ctrl_en and ctrl_led0..3 every clock; target_i = en_q & led_i_q, giving 255 if set, else 0.
REQ-011 SHALL keep a prescaler that counts 0..PRESCALE-1 and wraps; tick is asserted in the cycle the prescaler equals PRESCALE-1.
REQ-012 SHALL keep an 8-bit pwm_cnt that increments on tick and wraps 255->0; the PWM period is 256*PRESCALE clocks.
REQ-013 SHALL assert period_end when tick is high and pwm_cnt==255.
REQ-014 SHALL keep an 8-bit level per LED that changes only on period_end.
REQ-015 When target is 255, a level SHALL rise by STEP on period_end, saturating at 255 (9-bit sum, clamp).
REQ-016 When target is 0, a level SHALL fall by STEP on period_end, saturating at 0 (no underflow).
REQ-017 A level already equal to its target SHALL hold.
REQ-018 lit_i SHALL be (level_i==255) | (level_i > pwm_cnt), so that level 255 is always on and level 0 is always off.
REQ-019 Each led_i SHALL be a flop of lit_i XOR ACTIVE_LOW, giving one clock latency from the pwm_cnt/level change.
REQ-020 When en_q==0, all levels SHALL clear to 0 on the next clock regardless of period_end, and all leds SHALL be inactive on the following clock.
REQ-021 While en_q==0, the prescaler and pwm_cnt SHALL continue counting.
REQ-022 A target change mid-period SHALL take effect only at the next period_end (en_q falling excepted).
REQ-023 ramping SHALL be registered, equal to en_q & OR over i of (level_i != target_i).
REQ-024 With PRESCALE==1, tick SHALL be high every clock.

Reset
REQ-025 On rst high, prescaler, pwm_cnt, all levels, all input registers and ramping SHALL be 0 immediately (asynchronously).
REQ-026 On rst high, led0..3 SHALL be inactive (value equal to ACTIVE_LOW).
REQ-027 Reset asserted mid-ramp or mid-period SHALL discard all progress; after release, ramps restart from level 0 at pwm_cnt 0.

Verification (bench uses PRESCALE=1, STEP=64, ACTIVE_LOW=0 unless noted)
REQ-028 Pulse rst, hold inputs 0 -> led0..3=0, ramping=0, and pwm_cnt wraps every 256 clocks.
REQ-029 Set ctrl_en=1, ctrl_led0=1 -> level0 goes 0,64,128,192,255 on successive period_end; led0 is high for 64 of 256 clocks in the first full period; ramping drops after reaching 255; led0 is then constantly 1.
REQ-030 With led0 at 255, clear ctrl_led0 -> level0 goes 191,127,63,0; led0 is constantly 0 after the last step; led1..3 stay 0 throughout.
REQ-031 With all four LEDs ramping up, deassert ctrl_en at pwm_cnt=100 -> levels are 0 two clocks later; led0..3=0 and ramping=0 by the third clock; counters are not reset.
REQ-032 Assert rst at level0=128, pwm_cnt=50 -> all state is 0 at once; after release with inputs still set, the ramp restarts at 0->64.
REQ-033 ACTIVE_LOW=1, PRESCALE=3, STEP=255 -> reset drives pins to 1; one period_end (768 clocks) after enabling led2, led2 is constantly 0; other pins stay 1.

Source files
------------

// File: rtl/leds_driver.sv
// -----------------------------------------------------------------------------
// leds_driver
//
// Four-channel LED PWM driver. Each LED fades between off and full
// brightness. Its brightness level moves by STEP once per PWM period,
// towards the target its request bit selects. The PWM counter advances
// once every PRESCALE clocks, so one PWM period lasts 256*PRESCALE clocks.
//
// Parameters:
//   PRESCALE   - clocks per PWM tick (1..65535)
//   STEP       - level change per PWM period (1..255)
//   ACTIVE_LOW - 1: pins are driven low for "lit"
//
// Ports:
//   clk              - clock, rising-edge active
//   rst              - asynchronous active-high reset
//   ctrl_en          - global enable; when low, all LEDs go dark at once
//   ctrl_led0..3     - requested on/off state per LED
//   led0..3          - registered PWM pin drive
//   ramping          - high while any enabled level differs from its target
// -----------------------------------------------------------------------------
module leds_driver #(
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned STEP       = 16,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ctrl_en,
    input  logic ctrl_led0,
    input  logic ctrl_led1,
    input  logic ctrl_led2,
    input  logic ctrl_led3,
    output logic led0,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic ramping
);

    localparam logic [15:0] PresLast = 16'(PRESCALE - 1);
    localparam logic [8:0]  StepUp   = 9'(STEP);
    localparam logic [7:0]  StepDn   = 8'(STEP);
    localparam logic        Inactive = (ACTIVE_LOW != 0);

    logic        en_q;
    logic [3:0]  req_q;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        tick, period_end;
    logic [3:0]  target, lit, mismatch;
    logic [3:0]  led_q, led_d;
    logic        ramping_q, ramping_d;

    // Input capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q  <= 1'b0;
            req_q <= 4'b0000;
        end else begin
            en_q  <= ctrl_en;
            req_q <= {ctrl_led3, ctrl_led2, ctrl_led1, ctrl_led0};
        end
    end

    assign target = {4{en_q}} & req_q;

    // Prescaler and PWM counter keep running even while disabled.
    always_comb begin
        tick       = (presc_q == PresLast);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_end = tick && (pwm_cnt_q == 8'hFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= 16'd0;
            pwm_cnt_q <= 8'd0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Per-LED brightness level.
    for (genvar i = 0; i < 4; i++) begin : g_led
        logic [7:0] level_q, level_d;
        logic [8:0] up_sum;

        assign up_sum = {1'b0, level_q} + StepUp;

        always_comb begin
            level_d = level_q;
            if (!en_q) begin
                // Disable bypasses the period boundary.
                level_d = 8'd0;
            end else if (period_end) begin
                if (target[i]) begin
                    level_d = up_sum[8] ? 8'hFF : up_sum[7:0];
                end else begin
                    level_d = (level_q > StepDn) ? level_q - StepDn : 8'd0;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q <= 8'd0;
            end else begin
                level_q <= level_d;
            end
        end

        // Level 255 must stay on for the count value 255 as well.
        assign lit[i]      = (level_q == 8'hFF) || (level_q > pwm_cnt_q);
        assign mismatch[i] = (level_q != (target[i] ? 8'hFF : 8'h00));
    end

    always_comb begin
        led_d     = lit ^ {4{Inactive}};
        ramping_d = en_q && (|mismatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= {4{Inactive}};
            ramping_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            ramping_q <= ramping_d;
        end
    end

    assign led0    = led_q[0];
    assign led1    = led_q[1];
    assign led2    = led_q[2];
    assign led3    = led_q[3];
    assign ramping = ramping_q;

endmodule
